// File: rtl/d_ext_alu_sched_pkg.sv
// Shared types and helpers for the D-extension ALU scheduler.
package d_ext_alu_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RES_D   = 2'd0,
        RES_INT = 2'd1,
        RES_S   = 2'd2
    } res_class_t;

    localparam logic [31:0] NANBOX_HI = 32'hFFFF_FFFF;

    // Opcodes 0-15 produce a double, 16-23 an integer, 24-31 a single.
    function automatic res_class_t op_class(input logic [4:0] op);
        res_class_t c;
        case (op[4:3])
            2'b00, 2'b01: c = RES_D;
            2'b10:        c = RES_INT;
            2'b11:        c = RES_S;
            default:      c = RES_D;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/d_ext_alu_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot grant selection
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/d_ext_alu_sched.sv
// Scheduler for the shared D-extension ALU: arbitrates two issue slots,
// drives registered operands to the ALU, waits LATENCY cycles and returns
// the class-appropriate result with the requester's id and tag.
module d_ext_alu_sched
    import d_ext_alu_sched_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [9:0]           req_op,
    input  logic [127:0]         req_rs1,
    input  logic [127:0]         req_rs2,
    input  logic [127:0]         req_rs3,
    input  logic [63:0]          req_fs_rs1,
    input  logic [127:0]         req_int_rs1,
    input  logic [2*TAG_W-1:0]   req_tag,
    output logic [63:0]          alu_rs1,
    output logic [63:0]          alu_rs2,
    output logic [63:0]          alu_rs3,
    output logic [31:0]          alu_fs_rs1,
    output logic [63:0]          alu_int_rs1,
    output logic [4:0]           alu_op,
    input  logic [63:0]          alu_result,
    input  logic [31:0]          alu_fs_result,
    input  logic [63:0]          alu_int_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic [63:0]          rsp_data,
    output logic                 busy
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic               r_last;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [TAG_W-1:0]   r_rsp_tag;
    logic [63:0]        r_rsp_data;
    logic [63:0]        r_alu_rs1;
    logic [63:0]        r_alu_rs2;
    logic [63:0]        r_alu_rs3;
    logic [31:0]        r_alu_fs_rs1;
    logic [63:0]        r_alu_int_rs1;
    logic [4:0]         r_alu_op;

    logic [1:0]         w_grant;
    logic               w_win;
    logic               w_accept;
    logic [TAG_W-1:0]   w_win_tag;
    logic [63:0]        w_result;

    rr_arb2 u_arb (
        .req   (req_valid),
        .last  (r_last),
        .grant (w_grant)
    );

    assign w_win     = w_grant[1];
    assign req_ready = ((r_state == ST_IDLE) && !rst) ? w_grant : 2'b00;
    assign w_accept  = |(req_valid & req_ready);
    assign w_win_tag = w_win ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];

    // Select the result bus matching the class of the in-flight opcode
    always_comb begin
        w_result = alu_result;
        case (op_class(r_alu_op))
            RES_D:   w_result = alu_result;
            RES_INT: w_result = alu_int_result;
            RES_S:   w_result = {NANBOX_HI, alu_fs_result};
            default: w_result = alu_result;
        endcase
    end

    // ALU operand registers: load the winner on accept, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_rs1     <= 64'd0;
            r_alu_rs2     <= 64'd0;
            r_alu_rs3     <= 64'd0;
            r_alu_fs_rs1  <= 32'd0;
            r_alu_int_rs1 <= 64'd0;
            r_alu_op      <= 5'd0;
        end else if (w_accept) begin
            r_alu_rs1     <= w_win ? req_rs1[127:64]     : req_rs1[63:0];
            r_alu_rs2     <= w_win ? req_rs2[127:64]     : req_rs2[63:0];
            r_alu_rs3     <= w_win ? req_rs3[127:64]     : req_rs3[63:0];
            r_alu_fs_rs1  <= w_win ? req_fs_rs1[63:32]   : req_fs_rs1[31:0];
            r_alu_int_rs1 <= w_win ? req_int_rs1[127:64] : req_int_rs1[63:0];
            r_alu_op      <= w_win ? req_op[9:5]         : req_op[4:0];
        end else begin
            r_alu_rs1     <= r_alu_rs1;
            r_alu_rs2     <= r_alu_rs2;
            r_alu_rs3     <= r_alu_rs3;
            r_alu_fs_rs1  <= r_alu_fs_rs1;
            r_alu_int_rs1 <= r_alu_int_rs1;
            r_alu_op      <= r_alu_op;
        end
    end

    // Scheduler FSM with registered response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_last      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_tag   <= '0;
            r_rsp_data  <= 64'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_last    <= w_win;
                        r_cnt     <= CNT_INIT;
                        r_rsp_id  <= w_win;
                        r_rsp_tag <= w_win_tag;
                        r_state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rsp_data  <= w_result;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_rs1     = r_alu_rs1;
    assign alu_rs2     = r_alu_rs2;
    assign alu_rs3     = r_alu_rs3;
    assign alu_fs_rs1  = r_alu_fs_rs1;
    assign alu_int_rs1 = r_alu_int_rs1;
    assign alu_op      = r_alu_op;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_tag     = r_rsp_tag;
    assign rsp_data    = r_rsp_data;
    assign busy        = (r_state != ST_IDLE);

endmodule
